// File: rtl/bus_slave_router_pkg.sv
// Shared definitions for the system-bus master-side router: FSM states,
// slave index constants, default data width and the slave one-hot decode.
package bus_slave_router_pkg;

    localparam int BUS_DATA_W = 32;

    localparam logic [1:0] SLV0        = 2'b00;
    localparam logic [1:0] SLV1        = 2'b01;
    localparam logic [1:0] SLV2        = 2'b10;
    localparam logic [1:0] SLV_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } bus_state_e;

    // The invalid index maps to no request at all, so nothing on the bus moves.
    function automatic logic [2:0] slave_onehot(input logic [1:0] sel);
        logic [2:0] onehot;
        case (sel)
            SLV0:    onehot = 3'b001;
            SLV1:    onehot = 3'b010;
            SLV2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/bus_slave_router_if.sv
// Master request channel plus the three-slave request/ack channel and the
// read-mux select, as seen by the router, the upstream master and the slaves.
interface bus_slave_router_if
    import bus_slave_router_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = BUS_DATA_W
);
    logic              m_valid;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_err;

    logic [2:0]        s_req;
    logic              s_write;
    logic [ADDR_W-3:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [2:0]        s_ack;
    logic [1:0]        rd_sel;

    modport router (
        input  m_valid, m_write, m_addr, m_wdata, s_ack,
        output m_ready, m_err, s_req, s_write, s_addr, s_wdata, rd_sel
    );

    modport master (
        output m_valid, m_write, m_addr, m_wdata,
        input  m_ready, m_err, rd_sel
    );

    modport slave (
        input  s_req, s_write, s_addr, s_wdata,
        output s_ack
    );

endinterface

// File: rtl/bus_slave_router_timeout.sv
// BUSY-cycle counter for the router: cleared on each BUSY entry, counts while
// enabled and saturates at TIMEOUT-1, where it flags expiry.
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_r;
    logic             expired_s;

    assign expired_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign expired   = expired_s;

    // Cycle counter; holds at the expiry value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !expired_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/bus_slave_router.sv
// Master-side request router: decodes the slave from the top address bits,
// holds a one-hot request until ack or timeout, then pulses completion/error.
module bus_slave_router
    import bus_slave_router_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_slave_router_if.router   bus
);
    bus_state_e        state_r, state_s;

    logic [2:0]        s_req_r,   s_req_s;
    logic              s_write_r, s_write_s;
    logic [ADDR_W-3:0] s_addr_r,  s_addr_s;
    logic [DATA_W-1:0] s_wdata_r, s_wdata_s;
    logic [1:0]        rd_sel_r,  rd_sel_s;
    logic              m_ready_r, m_ready_s;
    logic              m_err_r,   m_err_s;

    logic [1:0]        sel_s;
    logic              ack_hit_s;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              expired_s;

    assign sel_s = bus.m_addr[ADDR_W-1 -: 2];
    // s_req_r is one-hot of the latched slave, so this picks only its ack.
    assign ack_hit_s = |(s_req_r & bus.s_ack);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (expired_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        s_req_s   = s_req_r;
        s_write_s = s_write_r;
        s_addr_s  = s_addr_r;
        s_wdata_s = s_wdata_r;
        rd_sel_s  = rd_sel_r;
        m_ready_s = 1'b0;
        m_err_s   = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    s_write_s = bus.m_write;
                    s_addr_s  = bus.m_addr[ADDR_W-3:0];
                    s_wdata_s = bus.m_wdata;
                    rd_sel_s  = sel_s;
                    if (sel_s == SLV_INVALID) begin
                        s_req_s   = 3'b000;
                        m_ready_s = 1'b1;
                        m_err_s   = 1'b1;
                        state_s   = ST_DONE;
                    end else begin
                        s_req_s   = slave_onehot(sel_s);
                        cnt_clr_s = 1'b1;
                        state_s   = ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_hit_s) begin
                    s_req_s   = 3'b000;
                    m_ready_s = 1'b1;
                    m_err_s   = 1'b0;
                    state_s   = ST_DONE;
                end else if (expired_s) begin
                    s_req_s   = 3'b000;
                    m_ready_s = 1'b1;
                    m_err_s   = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                s_req_s = 3'b000;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bus outputs; reset drops any in-flight slave request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_req_r   <= 3'b000;
            s_write_r <= 1'b0;
            s_addr_r  <= {(ADDR_W-2){1'b0}};
            s_wdata_r <= {DATA_W{1'b0}};
            rd_sel_r  <= 2'b00;
            m_ready_r <= 1'b0;
            m_err_r   <= 1'b0;
        end else begin
            s_req_r   <= s_req_s;
            s_write_r <= s_write_s;
            s_addr_r  <= s_addr_s;
            s_wdata_r <= s_wdata_s;
            rd_sel_r  <= rd_sel_s;
            m_ready_r <= m_ready_s;
            m_err_r   <= m_err_s;
        end
    end

    assign bus.s_req   = s_req_r;
    assign bus.s_write = s_write_r;
    assign bus.s_addr  = s_addr_r;
    assign bus.s_wdata = s_wdata_r;
    assign bus.rd_sel  = rd_sel_r;
    assign bus.m_ready = m_ready_r;
    assign bus.m_err   = m_err_r;

endmodule

// File: tb/tb_bus_slave_router.sv
// Randomized and directed bench for bus_slave_router against a per-transaction
// timeline model (request window, completion cycle, error) derived from the bus rules.
module tb_bus_slave_router;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   ready_pulses;

    bus_slave_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    bus_slave_router #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus_if.m_ready) ready_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at the negedge of an IDLE cycle; returns at the negedge of the IDLE
    // cycle following completion. ack_dly = BUSY cycles before the addressed slave
    // acks (>= TIMEOUT means never). noise: 0 none, 1 other slaves always ack, 2 random.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input int ack_dly, input int noise);
        logic [1:0] sel;
        logic       valid;
        logic [2:0] onehot;
        logic [2:0] ack;
        int         busy_len;
        int         done_c;
        logic       exp_err;
        logic       exp_rdy;
        sel      = addr[15:14];
        valid    = (sel != 2'b11);
        onehot   = valid ? (3'b001 << sel) : 3'b000;
        busy_len = (ack_dly < TIMEOUT) ? ack_dly + 1 : TIMEOUT;
        done_c   = valid ? busy_len + 1 : 1;
        exp_err  = !valid || (ack_dly >= TIMEOUT);

        check("idle_req", {61'd0, bus_if.s_req}, 64'd0);
        check("idle_ready", {63'd0, bus_if.m_ready}, 64'd0);
        bus_if.m_valid = 1'b1;
        bus_if.m_write = wr;
        bus_if.m_addr  = addr;
        bus_if.m_wdata = wdata;
        bus_if.s_ack   = 3'b000;
        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rdy = (c == done_c);
            check("s_req", {61'd0, bus_if.s_req},
                  (valid && c <= busy_len) ? {61'd0, onehot} : 64'd0);
            check("m_ready", {63'd0, bus_if.m_ready}, {63'd0, exp_rdy});
            check("m_err", {63'd0, bus_if.m_err}, {63'd0, exp_rdy & exp_err});
            if (c == 1 || exp_rdy) begin
                check("rd_sel", {62'd0, bus_if.rd_sel}, {62'd0, sel});
                check("s_addr", {50'd0, bus_if.s_addr}, {50'd0, addr[13:0]});
                check("s_write", {63'd0, bus_if.s_write}, {63'd0, wr});
                check("s_wdata", {32'd0, bus_if.s_wdata}, {32'd0, wdata});
            end
            if (exp_rdy) bus_if.m_valid = 1'b0;
            ack = 3'b000;
            if (noise == 1) ack = ~onehot;
            if (noise == 2) ack = 3'($urandom_range(0, 7)) & ~onehot;
            if (valid && (c - 1) >= ack_dly) ack = ack | onehot;
            bus_if.s_ack = exp_rdy ? 3'b000 : ack;
        end
        @(posedge clk);
        @(negedge clk);
        check("post_ready", {63'd0, bus_if.m_ready}, 64'd0);
        check("post_req", {61'd0, bus_if.s_req}, 64'd0);
        check("rd_sel_hold", {62'd0, bus_if.rd_sel}, {62'd0, sel});
    endtask

    initial begin
        logic [31:0] slave_rdata [3];
        logic [31:0] mux_out;
        int          base;
        n_checks       = 0;
        n_fails        = 0;
        ready_pulses   = 0;
        rst            = 1'b1;
        bus_if.m_valid = 1'b0;
        bus_if.m_write = 1'b0;
        bus_if.m_addr  = 16'h0000;
        bus_if.m_wdata = 32'h0;
        bus_if.s_ack   = 3'b000;
        slave_rdata[0] = 32'h1111_0000;
        slave_rdata[1] = 32'h2222_0001;
        slave_rdata[2] = 32'h3333_0002;

        @(negedge clk);
        @(negedge clk);
        check("rst_req", {61'd0, bus_if.s_req}, 64'd0);
        check("rst_ready", {63'd0, bus_if.m_ready}, 64'd0);
        check("rst_err", {63'd0, bus_if.m_err}, 64'd0);
        check("rst_rd_sel", {62'd0, bus_if.rd_sel}, 64'd0);
        check("rst_s_wdata", {32'd0, bus_if.s_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: write, fast read with mux, invalid slave, timeout with noise.
        run_txn(1'b1, 16'h4010, 32'hDEADBEEF, 2, 0);
        run_txn(1'b0, 16'h8004, 32'h0, 0, 0);
        mux_out = slave_rdata[bus_if.rd_sel];
        check("mux_slave2", {32'd0, mux_out}, {32'd0, slave_rdata[2]});
        run_txn(1'b0, 16'hC000, 32'h5, 0, 2);
        run_txn(1'b0, 16'h0123, 32'h0, NEVER, 1);
        run_txn(1'b1, 16'h0044, 32'h77, TIMEOUT - 1, 0);

        // Asynchronous reset in the middle of BUSY.
        bus_if.m_valid = 1'b1;
        bus_if.m_write = 1'b1;
        bus_if.m_addr  = 16'h0123;
        bus_if.m_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus_if.m_valid = 1'b0;
        check("pre_rst_req", {61'd0, bus_if.s_req}, 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {61'd0, bus_if.s_req}, 64'd0);
        check("arst_addr", {50'd0, bus_if.s_addr}, 64'd0);
        check("arst_write", {63'd0, bus_if.s_write}, 64'd0);
        check("arst_wdata", {32'd0, bus_if.s_wdata}, 64'd0);
        check("arst_rd_sel", {62'd0, bus_if.rd_sel}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b0, 16'h8ABC, 32'h0, 1, 0);

        // Back-to-back immediate acks to slaves 0, 2, 1.
        base = ready_pulses;
        run_txn(1'b1, 16'h0001, 32'hA0, 0, 0);
        run_txn(1'b1, 16'h8002, 32'hA2, 0, 0);
        run_txn(1'b1, 16'h4003, 32'hA1, 0, 0);
        check("b2b_pulses", 64'(ready_pulses - base), 64'd3);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                    $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
